// File: rtl/id_ex_register_if.sv
// ID/EX pipeline bus: ID-side instruction fields, squash request, EX-side
// registered fields, slot-valid flag and the load-use stall request.
// master: the ID stage / hazard logic side; slave: the pipeline register.
interface id_ex_register_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] pc_id;
  logic [XLEN-1:0] RUrs1_id;
  logic [XLEN-1:0] RUrs2_id;
  logic [XLEN-1:0] imm_id;
  logic [4:0]      rs1_id;
  logic [4:0]      rs2_id;
  logic [4:0]      rd_id;
  logic            RUWr_id;
  logic            MemRd_id;
  logic [13:0]     ctrl_id;
  logic            flush_ex;

  logic [XLEN-1:0] pc_ex;
  logic [XLEN-1:0] RUrs1_ex;
  logic [XLEN-1:0] RUrs2_ex;
  logic [XLEN-1:0] imm_ex;
  logic [4:0]      rs1_ex;
  logic [4:0]      rs2_ex;
  logic [4:0]      rd_ex;
  logic            RUWr_ex;
  logic            MemRd_ex;
  logic [13:0]     ctrl_ex;
  logic            valid_ex;
  logic            stall;

  modport master (
    output pc_id, RUrs1_id, RUrs2_id, imm_id, rs1_id, rs2_id, rd_id,
           RUWr_id, MemRd_id, ctrl_id, flush_ex,
    input  pc_ex, RUrs1_ex, RUrs2_ex, imm_ex, rs1_ex, rs2_ex, rd_ex,
           RUWr_ex, MemRd_ex, ctrl_ex, valid_ex, stall
  );

  modport slave (
    input  pc_id, RUrs1_id, RUrs2_id, imm_id, rs1_id, rs2_id, rd_id,
           RUWr_id, MemRd_id, ctrl_id, flush_ex,
    output pc_ex, RUrs1_ex, RUrs2_ex, imm_ex, rs1_ex, rs2_ex, rd_ex,
           RUWr_ex, MemRd_ex, ctrl_ex, valid_ex, stall
  );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection and squash.
// A bubble (all fields zero, valid_ex=0) is inserted on flush_ex or on a
// load-use hazard; flush wins and suppresses stall since the ID instruction
// is discarded anyway.
// Optional feature: define ID_EX_BUBBLE_CNT_EN to add the saturating
// 16-bit bubble_cnt output.
module id_ex_register #(
  parameter int unsigned XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  id_ex_register_if.slave      bus
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]          bubble_cnt
`endif
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic            r_ruwr;
  logic            r_memrd;
  logic [13:0]     r_ctrl;
  logic            r_valid;

  logic            w_load_use;
  logic            w_bubble;

  // Hazard detection from the EX-slot load against the ID source indices.
  always_comb begin
    w_load_use = r_memrd && r_ruwr && (r_rd != 5'd0) &&
                 ((r_rd == bus.rs1_id) || (r_rd == bus.rs2_id));
    w_bubble   = bus.flush_ex || w_load_use;
  end

  assign bus.stall = w_load_use && !bus.flush_ex;

  // Pipeline register: reset, then bubble, else capture the ID instruction.
  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ruwr     <= 1'b0;
      r_memrd    <= 1'b0;
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_pc       <= bus.pc_id;
      r_rs1_data <= bus.RUrs1_id;
      r_rs2_data <= bus.RUrs2_id;
      r_imm      <= bus.imm_id;
      r_rs1      <= bus.rs1_id;
      r_rs2      <= bus.rs2_id;
      r_rd       <= bus.rd_id;
      r_ruwr     <= bus.RUWr_id;
      r_memrd    <= bus.MemRd_id;
      r_ctrl     <= bus.ctrl_id;
      r_valid    <= 1'b1;
    end
  end

  assign bus.pc_ex    = r_pc;
  assign bus.RUrs1_ex = r_rs1_data;
  assign bus.RUrs2_ex = r_rs2_data;
  assign bus.imm_ex   = r_imm;
  assign bus.rs1_ex   = r_rs1;
  assign bus.rs2_ex   = r_rs2;
  assign bus.rd_ex    = r_rd;
  assign bus.RUWr_ex  = r_ruwr;
  assign bus.MemRd_ex = r_memrd;
  assign bus.ctrl_ex  = r_ctrl;
  assign bus.valid_ex = r_valid;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] r_bubble_cnt;

  // Saturating count of inserted bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: directed hazard scenarios plus
// randomized traffic checked against a rule-level reference model.
module tb_id_ex_register;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ruwr;
    logic        memrd;
    logic [13:0] ctrl;
  } in_t;

  typedef struct packed {
    in_t  f;
    logic valid;
  } ex_t;

  logic clk = 1'b0;
  logic rst;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  id_ex_register_if #(.XLEN(32)) bus ();

  id_ex_register #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;

  ex_t  m_ex;
  int   m_cnt;
  in_t  cur_in;
  logic cur_rst;
  logic cur_fl;

  function automatic logic model_hazard(input ex_t s, input in_t x);
    return s.f.memrd && s.f.ruwr && (s.f.rd != 0) &&
           (s.f.rd == x.rs1 || s.f.rd == x.rs2);
  endfunction

  function automatic logic exp_stall();
    return model_hazard(m_ex, cur_in) && !cur_fl;
  endfunction

  function automatic ex_t get_ex();
    ex_t e;
    e.f.pc    = bus.pc_ex;
    e.f.rs1d  = bus.RUrs1_ex;
    e.f.rs2d  = bus.RUrs2_ex;
    e.f.imm   = bus.imm_ex;
    e.f.rs1   = bus.rs1_ex;
    e.f.rs2   = bus.rs2_ex;
    e.f.rd    = bus.rd_ex;
    e.f.ruwr  = bus.RUWr_ex;
    e.f.memrd = bus.MemRd_ex;
    e.f.ctrl  = bus.ctrl_ex;
    e.valid   = bus.valid_ex;
    return e;
  endfunction

  function automatic in_t rand_in(input int unsigned maxreg);
    in_t x;
    x.pc    = $urandom;
    x.rs1d  = $urandom;
    x.rs2d  = $urandom;
    x.imm   = $urandom;
    x.rs1   = 5'($urandom_range(maxreg));
    x.rs2   = 5'($urandom_range(maxreg));
    x.rd    = 5'($urandom_range(maxreg));
    x.ruwr  = 1'($urandom_range(1));
    x.memrd = 1'($urandom_range(1));
    x.ctrl  = 14'($urandom);
    return x;
  endfunction

  task automatic drive(input in_t x, input logic r, input logic fl);
    bus.pc_id    = x.pc;
    bus.RUrs1_id = x.rs1d;
    bus.RUrs2_id = x.rs2d;
    bus.imm_id   = x.imm;
    bus.rs1_id   = x.rs1;
    bus.rs2_id   = x.rs2;
    bus.rd_id    = x.rd;
    bus.RUWr_id  = x.ruwr;
    bus.MemRd_id = x.memrd;
    bus.ctrl_id  = x.ctrl;
    bus.flush_ex = fl;
    rst          = r;
    cur_in  = x;
    cur_rst = r;
    cur_fl  = fl;
    #1;
  endtask

  // Advance one clock edge and move the model by the architectural rules.
  task automatic tick();
    ex_t  nx;
    logic bub;
    bub = cur_fl || model_hazard(m_ex, cur_in);
    if (cur_rst || bub) nx = '0;
    else begin
      nx.f     = cur_in;
      nx.valid = 1'b1;
    end
    @(posedge clk);
    m_ex = nx;
    if (cur_rst) m_cnt = 0;
    else if (bub && m_cnt < 65535) m_cnt++;
    #1;
  endtask

  task automatic do_reset();
    drive(rand_in(31), 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    drive(rand_in(31), 1'b1, 1'b1);
    tick();
    checks++;
    if (get_ex() !== ex_t'('0)) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", get_ex());
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    checks++;
    if (bubble_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", bubble_cnt);
    end
`endif
  endtask

  task automatic test_capture();
    in_t x;
    do_reset();
    x = rand_in(31);
    x.pc = 32'h40; x.rd = 5'd5; x.ruwr = 1'b1;
    drive(x, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL capture_stall: got %b expected 0", bus.stall);
    end
    tick();
    checks++;
    if (bus.pc_ex !== 32'h40 || bus.rd_ex !== 5'd5 || bus.valid_ex !== 1'b1 ||
        get_ex() !== m_ex) begin
      errors++;
      $display("FAIL capture_fields: got %h expected %h", get_ex(), m_ex);
    end
  endtask

  task automatic test_load_use();
    in_t ld, dep;
    do_reset();
    ld = rand_in(31);
    ld.memrd = 1'b1; ld.ruwr = 1'b1; ld.rd = 5'd8; ld.rs1 = 5'd1; ld.rs2 = 5'd2;
    drive(ld, 1'b0, 1'b0);
    tick();
    dep = rand_in(31);
    dep.rs1 = 5'd3; dep.rs2 = 5'd8;
    drive(dep, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL loaduse_stall: got %b expected 1", bus.stall);
    end
    tick();
    checks++;
    if (bus.valid_ex !== 1'b0 || bus.RUWr_ex !== 1'b0 || get_ex() !== ex_t'('0)) begin
      errors++;
      $display("FAIL loaduse_bubble: got %h expected 0", get_ex());
    end
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL loaduse_release: got %b expected 0", bus.stall);
    end
    tick();
    checks++;
    if (bus.valid_ex !== 1'b1 || get_ex() !== ex_t'({dep, 1'b1})) begin
      errors++;
      $display("FAIL loaduse_capture: got %h expected %h", get_ex(), {dep, 1'b1});
    end
  endtask

  task automatic test_x0();
    in_t ld, nxt;
    do_reset();
    ld = rand_in(31);
    ld.memrd = 1'b1; ld.ruwr = 1'b1; ld.rd = 5'd0;
    drive(ld, 1'b0, 1'b0);
    tick();
    nxt = rand_in(31);
    nxt.rs1 = 5'd0; nxt.rs2 = 5'd0;
    drive(nxt, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL x0_stall: got %b expected 0", bus.stall);
    end
    tick();
    checks++;
    if (get_ex() !== ex_t'({nxt, 1'b1})) begin
      errors++;
      $display("FAIL x0_capture: got %h expected %h", get_ex(), {nxt, 1'b1});
    end
  endtask

  task automatic test_flush_and_hazard();
    in_t ld, dep;
    int  c0;
    do_reset();
    ld = rand_in(31);
    ld.memrd = 1'b1; ld.ruwr = 1'b1; ld.rd = 5'd12; ld.rs1 = 5'd0; ld.rs2 = 5'd0;
    drive(ld, 1'b0, 1'b0);
    tick();
    c0 = m_cnt;
    dep = rand_in(31);
    dep.rs1 = 5'd12;
    drive(dep, 1'b0, 1'b1);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL flushhaz_stall: got %b expected 0", bus.stall);
    end
    tick();
    checks++;
    if (get_ex() !== ex_t'('0)) begin
      errors++;
      $display("FAIL flushhaz_bubble: got %h expected 0", get_ex());
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    checks++;
    if (bubble_cnt !== 16'(c0 + 1)) begin
      errors++;
      $display("FAIL flushhaz_cnt: got %0d expected %0d", bubble_cnt, c0 + 1);
    end
`endif
  endtask

  task automatic test_back_to_back();
    in_t x;
    do_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      x = rand_in(31);
      x.memrd = 1'b1; x.ruwr = 1'b1; x.rd = 5'(10 + i);
      x.rs1 = (i == 0) ? 5'd0 : 5'(9 + i);
      x.rs2 = 5'd0;
      drive(x, 1'b0, 1'b0);
      checks++;
      if (bus.stall !== ((i == 0) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL b2b_stall%0d: got %b expected %b", i, bus.stall, (i != 0));
      end
      if (i != 0) begin
        tick();
        checks++;
        if (get_ex() !== ex_t'('0)) begin
          errors++;
          $display("FAIL b2b_bubble%0d: got %h expected 0", i, get_ex());
        end
        #1;
      end
      tick();
      checks++;
      if (get_ex() !== ex_t'({x, 1'b1})) begin
        errors++;
        $display("FAIL b2b_capture%0d: got %h expected %h", i, get_ex(), {x, 1'b1});
      end
    end
  endtask

  task automatic test_random();
    in_t  x;
    logic fl;
    do_reset();
    for (int unsigned n = 0; n < 400; n++) begin
      x  = rand_in(3);
      fl = ($urandom_range(7) == 0);
      drive(x, 1'b0, fl);
      checks++;
      if (bus.stall !== exp_stall()) begin
        errors++;
        $display("FAIL rand_stall@%0d: got %b expected %b", n, bus.stall, exp_stall());
      end
      tick();
      checks++;
      if (get_ex() !== m_ex) begin
        errors++;
        $display("FAIL rand_ex@%0d: got %h expected %h", n, get_ex(), m_ex);
      end
`ifdef ID_EX_BUBBLE_CNT_EN
      checks++;
      if (bubble_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL rand_cnt@%0d: got %0d expected %0d", n, bubble_cnt, m_cnt);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_stall();
    in_t ld, dep;
    do_reset();
    ld = rand_in(31);
    ld.memrd = 1'b1; ld.ruwr = 1'b1; ld.rd = 5'd7; ld.rs1 = 5'd0; ld.rs2 = 5'd0;
    drive(ld, 1'b0, 1'b0);
    tick();
    dep = rand_in(31);
    dep.rs1 = 5'd7;
    drive(dep, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL rststall_pre: got %b expected 1", bus.stall);
    end
    drive(dep, 1'b1, 1'b0);
    tick();
    checks++;
    if (get_ex() !== ex_t'('0)) begin
      errors++;
      $display("FAIL rststall_state: got %h expected 0", get_ex());
    end
    drive(dep, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL rststall_after: got %b expected 0", bus.stall);
    end
  endtask

`ifdef ID_EX_BUBBLE_CNT_EN
  task automatic test_saturation();
    do_reset();
    for (int unsigned n = 0; n < 70000; n++) begin
      drive(rand_in(31), 1'b0, 1'b1);
      tick();
    end
    checks++;
    if (bubble_cnt !== 16'hFFFF || m_cnt != 65535) begin
      errors++;
      $display("FAIL sat_cnt: got %h expected ffff", bubble_cnt);
    end
    drive(rand_in(31), 1'b1, 1'b1);
    tick();
    checks++;
    if (bubble_cnt !== 16'd0) begin
      errors++;
      $display("FAIL sat_reset: got %h expected 0", bubble_cnt);
    end
  endtask
`endif

  initial begin
    m_ex  = '0;
    m_cnt = 0;
    drive('0, 1'b1, 1'b0);
    @(negedge clk);
    test_reset();
    test_capture();
    test_load_use();
    test_x0();
    test_flush_and_hazard();
    test_back_to_back();
    test_random();
    test_reset_mid_stall();
`ifdef ID_EX_BUBBLE_CNT_EN
    test_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
